// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: md-unit state encoding,
// mult/div latencies and the exception vector loaded into F/D on a request.
package pipe_ctrl_pkg;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam int         MD_CNT_W    = 4;
    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    typedef struct packed {
        logic start;
        logic is_div;
        logic kill;
    } md_req_t;

    function automatic logic [MD_CNT_W-1:0] md_load(input logic is_div);
        return is_div ? DIV_CYCLES : MULT_CYCLES;
    endfunction

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Mult/div busy timer: IDLE/BUSY state plus remaining-cycle counter.
// Compiled in only with PIPE_CTRL_MD_STALL_EN; otherwise outputs are tied to 0.
module md_timer
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  md_req_t             i_req,
    output logic                o_busy,
    output logic [MD_CNT_W-1:0] o_cnt
);

`ifdef PIPE_CTRL_MD_STALL_EN
    logic [0:0]          r_state;
    logic [MD_CNT_W-1:0] r_cnt;

    // A start killed by an exception in the same cycle never launches; starts
    // arriving while BUSY are dropped so the running count is never disturbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_req.start && !i_req.kill) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= md_load(i_req.is_div);
                    end
                end
                MD_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign o_busy = (r_state == MD_BUSY);
    assign o_cnt  = r_cnt;
`else
    logic w_unused;
    assign w_unused = ^{clk, reset, i_req};
    assign o_busy   = 1'b0;
    assign o_cnt    = '0;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/exception-request controller.
// Define PIPE_CTRL_MD_STALL_EN to include the mult/div busy stall term.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       d_stall_hz,
    input  logic       d_uses_md,
    input  logic       e_md_start,
    input  logic       e_md_is_div,
    input  logic       int_req,
    output logic       f_pc_en,
    output logic       fd_wren,
    output logic       de_flush,
    output logic       req,
    output logic       md_busy,
    output logic [3:0] md_cnt
);

    md_req_t w_md_req;
    logic    w_md_busy;
    logic    w_stall;
    logic    w_override;

    assign w_md_req.start  = e_md_start;
    assign w_md_req.is_div = e_md_is_div;
    assign w_md_req.kill   = int_req;

    md_timer u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .i_req  (w_md_req),
        .o_busy (w_md_busy),
        .o_cnt  (md_cnt)
    );

    assign md_busy = w_md_busy;

`ifdef PIPE_CTRL_MD_STALL_EN
    // A D-stage HI/LO user must wait both for a running op and one starting now.
    assign w_stall = d_stall_hz | (d_uses_md & (w_md_busy | e_md_start));
`else
    logic w_unused;
    assign w_unused = d_uses_md;
    assign w_stall  = d_stall_hz;
`endif

    // Reset and exception requests both force the front end to keep moving.
    assign req        = int_req & ~reset;
    assign w_override = reset | int_req;
    assign f_pc_en    = w_override | ~w_stall;
    assign fd_wren    = w_override | ~w_stall;
    assign de_flush   = ~w_override & w_stall;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; expectations track PIPE_CTRL_MD_STALL_EN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, d_stall_hz, d_uses_md, e_md_start, e_md_is_div, int_req;
    logic       f_pc_en, fd_wren, de_flush, req, md_busy;
    logic [3:0] md_cnt;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .d_stall_hz  (d_stall_hz),
        .d_uses_md   (d_uses_md),
        .e_md_start  (e_md_start),
        .e_md_is_div (e_md_is_div),
        .int_req     (int_req),
        .f_pc_en     (f_pc_en),
        .fd_wren     (fd_wren),
        .de_flush    (de_flush),
        .req         (req),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic pc, input logic fd, input logic fl, input logic rq);
        chk({tag, ".f_pc_en"},  {31'd0, f_pc_en},  {31'd0, pc});
        chk({tag, ".fd_wren"},  {31'd0, fd_wren},  {31'd0, fd});
        chk({tag, ".de_flush"}, {31'd0, de_flush}, {31'd0, fl});
        chk({tag, ".req"},      {31'd0, req},      {31'd0, rq});
    endtask

    task automatic chk_md(input string tag, input logic bz, input logic [3:0] cnt);
        chk({tag, ".md_busy"}, {31'd0, md_busy}, {31'd0, bz & MD_EN});
        chk({tag, ".md_cnt"},  {28'd0, md_cnt},  {28'd0, MD_EN ? cnt : 4'd0});
    endtask

    initial begin
        reset = 1'b1; d_stall_hz = 1'b0; d_uses_md = 1'b0;
        e_md_start = 1'b0; e_md_is_div = 1'b0; int_req = 1'b0;

        // Reset held two cycles
        tick(); tick();
        chk_md("rst", 1'b0, 4'd0);
        chk_ctl("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        d_stall_hz = 1'b1; int_req = 1'b1; #1;
        chk_ctl("rst_masks", 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b0; d_stall_hz = 1'b0; int_req = 1'b0; #1;
        chk_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // Hazard with and without exception
        d_stall_hz = 1'b1; #1;
        chk_ctl("hz", 1'b0, 1'b0, 1'b1, 1'b0);
        int_req = 1'b1; #1;
        chk_ctl("hz_exc", 1'b1, 1'b1, 1'b0, 1'b1);
        d_stall_hz = 1'b0; int_req = 1'b0;

        // Mult with no D user; retry-start and interrupt while busy are ignored
        tick();
        e_md_start = 1'b1; e_md_is_div = 1'b0; #1;
        chk_ctl("mul_start", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_md("mul_start", 1'b0, 4'd0);
        tick();
        for (int k = 5; k >= 1; k--) begin
            e_md_start  = (k == 3);
            e_md_is_div = (k == 3);
            int_req     = (k == 4);
            #1;
            chk_md($sformatf("mul_k%0d", k), 1'b1, 4'(k));
            tick();
        end
        e_md_start = 1'b0; e_md_is_div = 1'b0; int_req = 1'b0; #1;
        chk_md("mul_done", 1'b0, 4'd0);

        // Div with D user held: stalled N..N+10, released N+11
        d_uses_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1; #1;
        chk_ctl("div_n", !MD_EN, !MD_EN, MD_EN, 1'b0);
        tick();
        e_md_start = 1'b0; e_md_is_div = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk_ctl($sformatf("div_n%0d", c), !MD_EN, !MD_EN, MD_EN, 1'b0);
            chk_md($sformatf("div_n%0d", c), 1'b1, 4'(11 - c));
            tick();
        end
        #1;
        chk_ctl("div_rel", 1'b1, 1'b1, 1'b0, 1'b0);
        chk_md("div_rel", 1'b0, 4'd0);

        // Start killed by a same-cycle exception
        e_md_start = 1'b1; e_md_is_div = 1'b1; int_req = 1'b1; #1;
        chk_ctl("kill", 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        e_md_start = 1'b0; e_md_is_div = 1'b0; int_req = 1'b0; d_uses_md = 1'b0; #1;
        chk_md("kill_next", 1'b0, 4'd0);

        // Reset in the middle of a div
        e_md_start = 1'b1; e_md_is_div = 1'b1;
        tick();
        e_md_start = 1'b0; e_md_is_div = 1'b0;
        tick(); tick(); tick(); tick();
        chk_md("pre_rst", 1'b1, 4'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk_md("mid_rst", 1'b0, 4'd0);
        tick();
        chk_md("post_rst", 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have these ports, each as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- d_stall_hz  in  1  data-hazard stall request from decode (combinational).
- d_uses_md  in  1  instruction in D reads or writes HI/LO or issues mult/div.
- e_md_start  in  1  mult/div instruction in E starts this cycle.
- e_md_is_div  in  1  qualifies e_md_start: 1 = div, 0 = mult.
- int_req  in  1  exception/interrupt request from CP0 (M stage).
- f_pc_en  out  1  PC register write enable.
- fd_wren  out  1  F/D pipeline register write enable.
- de_flush  out  1  D/E register bubble insert.
- req  out  1  broadcast exception request to all pipeline registers.
- md_busy  out  1  mult/div unit busy.
- md_cnt  out  4  remaining busy cycles; 0 when idle.

Function
REQ-002 SHALL hold md state machine states IDLE and BUSY.
REQ-003 IDLE -> BUSY when e_md_start=1 and int_req=0; md_cnt loads 10 (div) or 5 (mult).
REQ-004 In BUSY, md_cnt SHALL decrement by 1 per cycle; BUSY -> IDLE on the edge where md_cnt==1, leaving md_cnt=0.
REQ-005 md_busy SHALL equal (state==BUSY), registered: asserted exactly 5 (mult) / 10 (div) cycles, starting the cycle after e_md_start.
REQ-006 e_md_start while BUSY SHALL be ignored; no reload, no restart.
REQ-007 e_md_start with int_req=1 in the same cycle SHALL NOT start the counter (the E instruction is flushed).
REQ-008 int_req while BUSY SHALL NOT abort the running count.
REQ-009 stall = d_stall_hz | (d_uses_md & (md_busy | e_md_start)), combinational, same cycle.
REQ-010 When int_req=0: f_pc_en = fd_wren = ~stall; de_flush = stall.
REQ-011 req = int_req & ~reset, combinational, zero latency.
REQ-012 When req=1, it SHALL take priority over stall: f_pc_en=1, fd_wren=1, de_flush=0.
REQ-013 Pipeline registers clear themselves on req; F/D loads PC 0x0000_4180.

Reset
REQ-014 reset SHALL be synchronous and active-high, with priority over all other inputs.
REQ-015 After reset: state=IDLE, md_cnt=0, md_busy=0.
REQ-016 While reset=1: req=0, f_pc_en=1, fd_wren=1, de_flush=0.
REQ-017 reset asserted mid-BUSY SHALL return the block to IDLE on that edge.

Configuration
REQ-018 Macro PIPE_CTRL_MD_STALL_EN defined: the md counter, states and md stall term SHALL be compiled in.
REQ-019 Macro not defined:
- md_busy=0 and md_cnt=0 constant.
- e_md_start, e_md_is_div and d_uses_md ignored.
- stall = d_stall_hz.

Structure
REQ-020 Shared package SHALL define:
- state encoding (IDLE=0, BUSY=1).
- MULT_CYCLES=5, DIV_CYCLES=10.
- exception vector 32'h0000_4180.
REQ-021 Sub-module md_timer SHALL contain the counter and state machine; stall and request logic SHALL stay in pipe_ctrl.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset: reset=1 for 2 cycles -> md_cnt=0, md_busy=0, fd_wren=1, de_flush=0, req=0.
- Mult: e_md_start=1, e_md_is_div=0 at cycle N -> md_busy=1 for cycles N+1..N+5, md_cnt 5,4,3,2,1, then 0.
- Div with D user: e_md_start=1, e_md_is_div=1, d_uses_md=1 held -> fd_wren=0 and de_flush=1 for cycles N..N+10, released at N+11.
- Start plus exception: e_md_start=1 and int_req=1 in the same cycle -> req=1, f_pc_en=1, de_flush=0; md_busy stays 0 next cycle.
- Hazard under exception: d_stall_hz=1 and int_req=1 -> req=1, fd_wren=1, de_flush=0; with int_req=0 -> fd_wren=0, de_flush=1.
- Reset mid-BUSY: reset=1 while md_cnt=6 -> next cycle md_cnt=0, md_busy=0.
